// File: rtl/sha256_pkg.sv
// Shared SHA-256 package: block geometry, padding constants, padder state
// encoding, and the IV / round-constant tables used by the compression core.
package sha256_pkg;

  localparam int BLOCK_W         = 512;
  localparam int BLOCK_BYTES     = 64;
  localparam int LEN_FIELD_BYTES = 8;
  localparam logic [7:0] PAD_MARKER = 8'h80;

  // Padder control states.
  typedef enum logic [2:0] {
    S_FILL     = 3'd0,
    S_OUT      = 3'd1,
    S_PAD      = 3'd2,
    S_PAD2     = 3'd3,
    S_OUT_LAST = 3'd4
  } pad_state_t;

  // Initial hash value H(0).
  localparam logic [31:0] SHA256_IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // Round constants K[0..63].
  localparam logic [31:0] SHA256_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

endpackage

// File: rtl/sha256_padder.sv
// SHA-256 message padder: collects a byte stream into a 512-bit block buffer,
// appends the 0x80 marker, zero fill and the 64-bit big-endian bit length,
// and hands blocks to the compression core with first/last flags.
// Optional build macro: SHA256_PAD_LENCHK_EN enables the sticky length
// overflow flag (len_err) and makes the bit-length counter saturate.
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  input  logic                 in_empty,
  output logic                 in_ready,
  output logic [BLOCK_W-1:0]   out_block,
  output logic                 out_valid,
  output logic                 out_first,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic                 len_err
);

  localparam int LEN_FIELD_W = LEN_FIELD_BYTES * 8;

  // Replace byte 'idx' of a block (byte 0 is the most significant byte).
  // Indices outside 0..63 leave the block untouched.
  function automatic logic [BLOCK_W-1:0] put_byte(
    input logic [BLOCK_W-1:0] blk,
    input logic [6:0]         idx,
    input logic [7:0]         val
  );
    logic [BLOCK_W-1:0] res;
    res = blk;
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      res[BLOCK_W-1-8*i -: 8] = (idx == 7'(i)) ? val : res[BLOCK_W-1-8*i -: 8];
    end
    return res;
  endfunction

  // Registered state
  pad_state_t          state_r;
  logic [BLOCK_W-1:0]  buf_r;
  logic [6:0]          idx_r;        // bytes held in the current block (0..64)
  logic [LEN_W-1:0]    bitlen_r;     // message length in bits so far
  logic                first_pend_r; // next emitted block starts a message
  logic                pad2_pend_r;  // a length-only block follows this one
  logic                marker0_r;    // that block carries 0x80 at byte 0
  logic                in_ready_r;
  logic                out_valid_r;
  logic                out_first_r;
  logic                out_last_r;

  // Next-state values
  pad_state_t          state_s;
  logic [BLOCK_W-1:0]  buf_s;
  logic [6:0]          idx_s;
  logic [LEN_W-1:0]    bitlen_s;
  logic                first_pend_s;
  logic                pad2_pend_s;
  logic                marker0_s;
  logic                in_ready_s;
  logic                out_valid_s;
  logic                out_first_s;
  logic                out_last_s;

  logic                beat_s;
  logic [LEN_FIELD_W-1:0] len64_s;

  assign beat_s  = in_valid & in_ready_r;
  assign len64_s = LEN_FIELD_W'(bitlen_r);

`ifdef SHA256_PAD_LENCHK_EN
  logic             len_err_r;
  logic             len_err_s;
  logic [LEN_W:0]   bitlen_sum_s;
  assign bitlen_sum_s = {1'b0, bitlen_r} + (LEN_W+1)'(4'd8);
`else
  logic [LEN_W-1:0] bitlen_inc_s;
  assign bitlen_inc_s = bitlen_r + LEN_W'(4'd8);
`endif

  // Next-state, buffer update and output-flag decode.
  always_comb begin
    state_s      = state_r;
    buf_s        = buf_r;
    idx_s        = idx_r;
    bitlen_s     = bitlen_r;
    first_pend_s = first_pend_r;
    pad2_pend_s  = pad2_pend_r;
    marker0_s    = marker0_r;
    in_ready_s   = in_ready_r;
    out_valid_s  = out_valid_r;
    out_first_s  = out_first_r;
    out_last_s   = out_last_r;
`ifdef SHA256_PAD_LENCHK_EN
    len_err_s    = len_err_r;
`endif

    case (state_r)
      S_FILL: begin
        if (beat_s) begin
          if (!in_empty) begin
            buf_s = put_byte(buf_r, idx_r, in_data);
            idx_s = idx_r + 7'd1;
`ifdef SHA256_PAD_LENCHK_EN
            if (bitlen_sum_s[LEN_W]) begin
              bitlen_s  = '1;
              len_err_s = 1'b1;
            end else begin
              bitlen_s  = bitlen_sum_s[LEN_W-1:0];
            end
`else
            bitlen_s = bitlen_inc_s;
`endif
          end else begin
            idx_s = idx_r;
          end
          if (in_last) begin
            // Message closed: pad on the next cycle.
            state_s    = S_PAD;
            in_ready_s = 1'b0;
          end else if (!in_empty && (idx_r == 7'd63)) begin
            // Buffer full mid-message: present it straight away.
            state_s     = S_OUT;
            in_ready_s  = 1'b0;
            out_valid_s = 1'b1;
            out_first_s = first_pend_r;
            out_last_s  = 1'b0;
            pad2_pend_s = 1'b0;
          end else begin
            state_s = S_FILL;
          end
        end else begin
          state_s = S_FILL;
        end
      end

      S_PAD: begin
        out_valid_s = 1'b1;
        out_first_s = first_pend_r;
        if (idx_r == 7'd64) begin
          // Full data block; marker and length go into a trailing block.
          state_s     = S_OUT;
          out_last_s  = 1'b0;
          pad2_pend_s = 1'b1;
          marker0_s   = 1'b1;
        end else if (idx_r <= 7'd55) begin
          // Marker and length both fit; bytes beyond idx are already zero.
          buf_s = put_byte(buf_r, idx_r, PAD_MARKER);
          buf_s[LEN_FIELD_W-1:0] = len64_s;
          state_s     = S_OUT_LAST;
          out_last_s  = 1'b1;
          pad2_pend_s = 1'b0;
        end else begin
          // Marker fits but the length field does not.
          buf_s       = put_byte(buf_r, idx_r, PAD_MARKER);
          state_s     = S_OUT;
          out_last_s  = 1'b0;
          pad2_pend_s = 1'b1;
          marker0_s   = 1'b0;
        end
      end

      S_PAD2: begin
        buf_s = '0;
        if (marker0_r) begin
          buf_s[BLOCK_W-1 -: 8] = PAD_MARKER;
        end else begin
          buf_s[BLOCK_W-1 -: 8] = 8'h00;
        end
        buf_s[LEN_FIELD_W-1:0] = len64_s;
        state_s     = S_OUT_LAST;
        out_valid_s = 1'b1;
        out_first_s = first_pend_r;
        out_last_s  = 1'b1;
        pad2_pend_s = 1'b0;
        marker0_s   = 1'b0;
      end

      S_OUT: begin
        if (out_ready) begin
          buf_s        = '0;
          idx_s        = 7'd0;
          out_valid_s  = 1'b0;
          out_first_s  = 1'b0;
          out_last_s   = 1'b0;
          first_pend_s = 1'b0;
          if (pad2_pend_r) begin
            state_s    = S_PAD2;
            in_ready_s = 1'b0;
          end else begin
            state_s    = S_FILL;
            in_ready_s = 1'b1;
          end
        end else begin
          state_s = S_OUT;
        end
      end

      S_OUT_LAST: begin
        if (out_ready) begin
          buf_s        = '0;
          idx_s        = 7'd0;
          bitlen_s     = '0;
          out_valid_s  = 1'b0;
          out_first_s  = 1'b0;
          out_last_s   = 1'b0;
          first_pend_s = 1'b1;
          pad2_pend_s  = 1'b0;
          marker0_s    = 1'b0;
          state_s      = S_FILL;
          in_ready_s   = 1'b1;
        end else begin
          state_s = S_OUT_LAST;
        end
      end

      default: begin
        // Unreachable encoding: fall back to an empty, idle buffer.
        state_s      = S_FILL;
        buf_s        = '0;
        idx_s        = 7'd0;
        bitlen_s     = '0;
        first_pend_s = 1'b1;
        pad2_pend_s  = 1'b0;
        marker0_s    = 1'b0;
        in_ready_s   = 1'b1;
        out_valid_s  = 1'b0;
        out_first_s  = 1'b0;
        out_last_s   = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_FILL;
      buf_r        <= '0;
      idx_r        <= 7'd0;
      bitlen_r     <= '0;
      first_pend_r <= 1'b1;
      pad2_pend_r  <= 1'b0;
      marker0_r    <= 1'b0;
      in_ready_r   <= 1'b1;
      out_valid_r  <= 1'b0;
      out_first_r  <= 1'b0;
      out_last_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      buf_r        <= buf_s;
      idx_r        <= idx_s;
      bitlen_r     <= bitlen_s;
      first_pend_r <= first_pend_s;
      pad2_pend_r  <= pad2_pend_s;
      marker0_r    <= marker0_s;
      in_ready_r   <= in_ready_s;
      out_valid_r  <= out_valid_s;
      out_first_r  <= out_first_s;
      out_last_r   <= out_last_s;
    end
  end

`ifdef SHA256_PAD_LENCHK_EN
  // Sticky length-overflow flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_err_r <= 1'b0;
    end else begin
      len_err_r <= len_err_s;
    end
  end
  assign len_err = len_err_r;
`else
  assign len_err = 1'b0;
`endif

  assign in_ready  = in_ready_r;
  assign out_block = buf_r;
  assign out_valid = out_valid_r;
  assign out_first = out_first_r;
  assign out_last  = out_last_r;

endmodule

// File: tb/tb_sha256_padder.sv
// Self-checking bench for sha256_padder: reset values, hand-written latency,
// stall and reset sequences, a table of boundary message lengths, and random
// messages checked against a byte-queue padding model. A second instance with
// LEN_W=8 exercises bit-length wrap (or saturation and len_err with
// SHA256_PAD_LENCHK_EN).
module tb_sha256_padder;
  import sha256_pkg::*;

`ifdef SHA256_PAD_LENCHK_EN
  localparam bit LENCHK = 1'b1;
`else
  localparam bit LENCHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [7:0]   in_data;
  logic         in_valid, in_last, in_empty, out_ready;
  logic         in_ready, out_valid, out_first, out_last, len_err;
  logic [511:0] out_block;
  logic         in_ready8, out_valid8, out_first8, out_last8, len_err8;
  logic [511:0] out_block8;

  sha256_padder dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_empty(in_empty), .in_ready(in_ready),
    .out_block(out_block), .out_valid(out_valid), .out_first(out_first),
    .out_last(out_last), .out_ready(out_ready), .len_err(len_err));

  sha256_padder #(.LEN_W(8)) dut8 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_empty(in_empty), .in_ready(in_ready8),
    .out_block(out_block8), .out_valid(out_valid8), .out_first(out_first8),
    .out_last(out_last8), .out_ready(out_ready), .len_err(len_err8));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [511:0] blk;
    bit           first;
    bit           last;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  len8_q[$];
  bit          err8_exp = 1'b0;

  // Pads a whole message as a byte list and slices it into expected blocks.
  function automatic void model_push(input logic [7:0] msg[$]);
    logic [7:0]      p[$];
    longint unsigned bl;
    int              nb;
    int              bits;
    p  = msg;
    bl = 64'(msg.size()) * 64'd8;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(8'(bl >> (8 * i)));
    nb = p.size() / 64;
    for (int k = 0; k < nb; k++) begin
      exp_t e;
      e.blk = '0;
      for (int i = 0; i < 64; i++) e.blk[511-8*i -: 8] = p[64*k+i];
      e.first = (k == 0);
      e.last  = (k == nb - 1);
      exp_q.push_back(e);
    end
    bits = 8 * msg.size();
    if (LENCHK) begin
      len8_q.push_back((bits > 255) ? 8'hFF : 8'(bits));
      if (bits > 255) err8_exp = 1'b1;
    end else begin
      len8_q.push_back(8'(bits % 256));
    end
  endfunction

  // ---------------- consumer / scoreboard ----------------
  bit           auto_c    = 1'b0;
  bit           holding   = 1'b0;
  logic [511:0] held_blk;
  int           blk_cnt   = 0;
  int           msg_blks  = 0;
  int           msgs_done = 0;
  logic [63:0]  last_lenf;

  initial begin
    forever begin
      @(negedge clk);
      if (auto_c) begin
        out_ready = ($urandom_range(0, 3) != 0);
        if (holding && out_valid) chk("hold_stable", out_block, held_blk);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_block: got block 0x%0h, expected none", out_block);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("blk", out_block, e.blk);
            chk("first", 512'(out_first), 512'(e.first));
            chk("last", 512'(out_last), 512'(e.last));
            chk("blk8_hi", {out_block8[511:64], 64'h0}, {e.blk[511:64], 64'h0});
            chk("flags8", {510'h0, out_first8, out_last8}, {510'h0, e.first, e.last});
          end
          blk_cnt++;
          if (out_last) begin
            msg_blks  = blk_cnt;
            blk_cnt   = 0;
            last_lenf = out_block[63:0];
            if (len8_q.size() != 0) chk("len8", 512'(out_block8[7:0]), 512'(len8_q.pop_front()));
            msgs_done++;
          end
          holding = 1'b0;
        end else begin
          holding  = out_valid;
          held_blk = out_block;
        end
      end else begin
        holding = 1'b0;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send_beat(input logic [7:0] d, input bit last, input bit empty);
    int t;
    in_valid = 1'b1; in_data = d; in_last = last; in_empty = empty;
    t = 0;
    while (!in_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL beat_timeout: got in_ready=0, expected 1 within 400 cycles");
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; in_empty = 1'b0;
  endtask

  task automatic send_msg(input logic [7:0] msg[$], input bit close_empty, input bit gaps);
    int n;
    n = msg.size();
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 4) == 0) begin
        if ($urandom_range(0, 1) == 0) @(negedge clk);
        else send_beat(8'($urandom_range(0, 255)), 1'b0, 1'b1);
      end
      send_beat(msg[i], (i == n - 1) && !close_empty, 1'b0);
    end
    if (n == 0 || close_empty) send_beat(8'h00, 1'b1, 1'b1);
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (msgs_done < target && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("msg_complete", 512'(msgs_done), 512'(target));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    err8_exp = 1'b0;
  endtask

  // ---------------- table ----------------
  typedef struct {
    int          len;
    int          nblk;
    logic [63:0] lenf;
    bit          close_empty;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish, expected finish before 900000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] abc_blk;
    logic [511:0] full_blk;
    logic [7:0]   m[$];

    vecs[0] = '{len: 3,   nblk: 1, lenf: 64'h18,  close_empty: 1'b0};
    vecs[1] = '{len: 0,   nblk: 1, lenf: 64'h0,   close_empty: 1'b1};
    vecs[2] = '{len: 55,  nblk: 1, lenf: 64'h1B8, close_empty: 1'b0};
    vecs[3] = '{len: 56,  nblk: 2, lenf: 64'h1C0, close_empty: 1'b0};
    vecs[4] = '{len: 63,  nblk: 2, lenf: 64'h1F8, close_empty: 1'b1};
    vecs[5] = '{len: 64,  nblk: 2, lenf: 64'h200, close_empty: 1'b0};
    vecs[6] = '{len: 65,  nblk: 2, lenf: 64'h208, close_empty: 1'b0};
    vecs[7] = '{len: 119, nblk: 2, lenf: 64'h3B8, close_empty: 1'b0};
    vecs[8] = '{len: 120, nblk: 3, lenf: 64'h3C0, close_empty: 1'b0};
    vecs[9] = '{len: 128, nblk: 3, lenf: 64'h400, close_empty: 1'b1};

    abc_blk = '0;
    abc_blk[511:480] = 32'h61626380;
    abc_blk[63:0]    = 64'h18;

    rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0;
    in_empty = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset values
    chk("rst_in_ready", 512'({in_ready, in_ready8}), 512'(2'b11));
    chk("rst_out_valid", 512'(out_valid), 512'(0));
    chk("rst_flags", 512'({out_first, out_last}), 512'(0));
    chk("rst_block", out_block, 512'h0);
    chk("rst_len_err", 512'({len_err, len_err8}), 512'(0));

    // "abc" with final-block latency
    send_beat(8'h61, 1'b0, 1'b0);
    send_beat(8'h62, 1'b0, 1'b0);
    send_beat(8'h63, 1'b1, 1'b0);
    chk("abc_lat_early", 512'(out_valid), 512'(0));
    @(negedge clk);
    chk("abc_lat", 512'(out_valid), 512'(1));
    chk("abc_blk", out_block, abc_blk);
    chk("abc_flags", 512'({out_first, out_last}), 512'(2'b11));

    // Consumer stalls 10 cycles while a new byte is offered
    in_valid = 1'b1; in_data = 8'h61; in_last = 1'b0; in_empty = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_blk", out_block, abc_blk);
      chk("stall_ctl", 512'({out_valid, out_first, out_last, in_ready}), 512'(4'b1110));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("stall_release", 512'({out_valid, in_ready}), 512'(2'b01));
    @(negedge clk);  // held 0x61 is taken now
    in_valid = 1'b0;
    send_beat(8'h62, 1'b0, 1'b0);
    send_beat(8'h63, 1'b1, 1'b0);
    @(negedge clk);
    chk("b2b_blk", out_block, abc_blk);
    chk("b2b_first", 512'({out_valid, out_first, out_last}), 512'(3'b111));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Full non-last block latency, then reset while it is on offer
    full_blk = '0;
    for (int i = 0; i < 64; i++) full_blk[511-8*i -: 8] = 8'(i);
    for (int i = 0; i < 64; i++) send_beat(8'(i), 1'b0, 1'b0);
    chk("full_lat", 512'({out_valid, out_first, out_last}), 512'(3'b110));
    chk("full_blk", out_block, full_blk);
    do_reset();
    chk("rst_out_drop", 512'({out_valid, in_ready}), 512'(2'b01));
    chk("rst_out_blk", out_block, 512'h0);

    // Reset mid-message; with LEN_W=8 the 32nd byte overflows
    for (int i = 0; i < 31; i++) send_beat(8'hA5, 1'b0, 1'b0);
    chk("len_err8_31", 512'(len_err8), 512'(0));
    send_beat(8'hA5, 1'b0, 1'b0);
    chk("len_err8_32", 512'(len_err8), 512'(LENCHK));
    do_reset();
    chk("rst_mid_msg", 512'({out_valid, in_ready, len_err8}), 512'(3'b010));
    send_beat(8'h61, 1'b0, 1'b0);
    send_beat(8'h62, 1'b0, 1'b0);
    send_beat(8'h63, 1'b1, 1'b0);
    @(negedge clk);
    chk("post_rst_abc", out_block, abc_blk);
    chk("post_rst_flags", 512'({out_valid, out_first, out_last}), 512'(3'b111));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Table of boundary lengths
    auto_c = 1'b1;
    foreach (vecs[v]) begin
      int target;
      m.delete();
      for (int i = 0; i < vecs[v].len; i++) m.push_back(8'($urandom_range(0, 255)));
      model_push(m);
      target = msgs_done + 1;
      send_msg(m, vecs[v].close_empty, 1'b0);
      wait_done(target);
      chk($sformatf("nblk_len%0d", vecs[v].len), 512'(msg_blks), 512'(vecs[v].nblk));
      chk($sformatf("lenf_len%0d", vecs[v].len), 512'(last_lenf), 512'(vecs[v].lenf));
      chk("len_err8_tbl", 512'(len_err8), 512'(err8_exp));
    end

    // Random messages with gaps, ignored empty beats and random back-pressure
    for (int r = 0; r < 25; r++) begin
      int target;
      m.delete();
      for (int i = 0; i < $urandom_range(0, 200); i++) m.push_back(8'($urandom_range(0, 255)));
      model_push(m);
      target = msgs_done + 1;
      send_msg(m, ($urandom_range(0, 3) == 0), 1'b1);
      wait_done(target);
      chk("len_err8_rnd", 512'(len_err8), 512'(err8_exp));
    end

    auto_c = 1'b0;
    @(negedge clk);
    chk("exp_q_empty", 512'(exp_q.size()), 512'(0));
    chk("len_err_w64", 512'(len_err), 512'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
